// File: rtl/sar_guesser.sv
// Successive-approximation guesser: binary-searches a hidden value by driving
// the comparator's guess operand and reading back its 2-bit verdict.
// A hidden value of 2^WIDTH values is located in at most WIDTH+1 guesses.
// Inconsistent or illegal comparator answers end the search in ERR; lo and
// hi never wrap around.
module sar_guesser #(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmp_in,
  output logic [WIDTH-1:0]  guess,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  found,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE,
    ERR
  } state_t;

  localparam logic [WIDTH-1:0]  MAXV      = '1;
  localparam logic [STEP_W-1:0] MAX_STEPS = STEP_W'(WIDTH + 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  lo, lo_nxt;
  logic [WIDTH-1:0]  hi, hi_nxt;
  logic [WIDTH-1:0]  guess_nxt;
  logic [WIDTH-1:0]  found_nxt;
  logic [STEP_W-1:0] steps_nxt;

  logic [WIDTH:0]    guess_up;
  logic [WIDTH-1:0]  guess_dn;

  // Midpoint of [a, b] using one extra bit so a+b cannot overflow.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  assign guess_up = {1'b0, guess} + {{WIDTH{1'b0}}, 1'b1};
  assign guess_dn = guess - {{(WIDTH-1){1'b0}}, 1'b1};

  // Status flags decode straight from the state register, so none of them
  // can see cmp_in combinationally.
  assign busy = (state == EVAL);
  assign done = (state == DONE);
  assign err  = (state == ERR);

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= MAXV;
      guess <= '0;
      found <= '0;
      steps <= '0;
    end else begin
      state <= state_nxt;
      lo    <= lo_nxt;
      hi    <= hi_nxt;
      guess <= guess_nxt;
      found <= found_nxt;
      steps <= steps_nxt;
    end
  end

  // Next-state logic: start launches a search from any non-busy state; in
  // EVAL the range is narrowed around the guess the comparator just judged.
  always_comb begin
    state_nxt = state;
    lo_nxt    = lo;
    hi_nxt    = hi;
    guess_nxt = guess;
    found_nxt = found;
    steps_nxt = steps;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          lo_nxt    = '0;
          hi_nxt    = MAXV;
          guess_nxt = midpoint('0, MAXV);
          steps_nxt = STEP_W'(1);
          found_nxt = '0;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        case (cmp_in)
          2'b00: begin
            found_nxt = guess;
            state_nxt = DONE;
          end
          2'b10: begin
            if (guess == MAXV || guess_up > {1'b0, hi} || steps >= MAX_STEPS) begin
              found_nxt = '0;
              state_nxt = ERR;
            end else begin
              lo_nxt    = guess_up[WIDTH-1:0];
              guess_nxt = midpoint(guess_up[WIDTH-1:0], hi);
              steps_nxt = steps + STEP_W'(1);
            end
          end
          2'b01: begin
            if (guess == '0 || guess_dn < lo || steps >= MAX_STEPS) begin
              found_nxt = '0;
              state_nxt = ERR;
            end else begin
              hi_nxt    = guess_dn;
              guess_nxt = midpoint(lo, guess_dn);
              steps_nxt = steps + STEP_W'(1);
            end
          end
          default: begin
            found_nxt = '0;
            state_nxt = ERR;
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_guesser.sv
// Scoreboard bench for sar_guesser: a behavioural binary-search model pushes
// expected guesses and results into queues at each start; an independent
// monitor pops and compares whenever the DUT presents a guess or a result.
module tb_sar_guesser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cmp_in;
  logic [5:0] guess;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] found;
  logic [3:0] steps;

  // Comparator behaviour: 0 honest, 1 always illegal, 2 always "greater",
  // 3 always "less".
  int mode;
  int hidden;

  int checks;
  int failures;

  typedef struct {
    bit d;
    bit e;
    int f;
    int s;
  } exp_t;

  logic [5:0] exp_guess_q[$];
  exp_t       result_q[$];

  sar_guesser #(.WIDTH(6), .STEP_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_in (cmp_in),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .found  (found),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator answering the DUT's current guess.
  always_comb begin
    case (mode)
      0: begin
        if (hidden > int'(guess))      cmp_in = 2'b10;
        else if (hidden < int'(guess)) cmp_in = 2'b01;
        else                           cmp_in = 2'b00;
      end
      1:       cmp_in = 2'b11;
      2:       cmp_in = 2'b10;
      default: cmp_in = 2'b01;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integer binary search over [0,63] with the
  // comparator's answer chosen by mode.
  task automatic pushExpected(input int m, input int h);
    int   lo;
    int   hi;
    int   g;
    int   st;
    int   a;
    bit   fin;
    exp_t r;
    lo  = 0;
    hi  = 63;
    st  = 0;
    fin = 0;
    r.d = 0; r.e = 0; r.f = 0; r.s = 0;
    while (!fin && st < 10) begin
      g = (lo + hi) / 2;
      exp_guess_q.push_back(6'(g));
      st++;
      case (m)
        0:       a = (h > g) ? 2 : ((h < g) ? 1 : 0);
        1:       a = 3;
        2:       a = 2;
        default: a = 1;
      endcase
      if (a == 0) begin
        r.d = 1; r.f = g; r.s = st; fin = 1;
      end else if (a == 3) begin
        r.e = 1; r.s = st; fin = 1;
      end else if (a == 2) begin
        if (g + 1 > hi || st >= 7) begin
          r.e = 1; r.s = st; fin = 1;
        end else begin
          lo = g + 1;
        end
      end else begin
        if (g - 1 < lo || st >= 7) begin
          r.e = 1; r.s = st; fin = 1;
        end else begin
          hi = g - 1;
        end
      end
    end
    result_q.push_back(r);
  endtask

  // Run one search; optionally pulse start while busy, which must be ignored.
  task automatic applyStimulus(input int m, input int h, input bit poke);
    int cycles;
    @(negedge clk);
    mode   = m;
    hidden = h;
    pushExpected(m, h);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!(done || err) && cycles < 20) begin
      start = (poke && cycles == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("[TB] FAIL search_timeout actual=%0d expected=<20 cycles mode=%0d hidden=%0d", cycles, m, h);
      exp_guess_q.delete();
      result_q.delete();
    end
  endtask

  // Monitor: one expected guess per busy cycle, one expected result when a
  // search ends.
  bit prev_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (exp_guess_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_guess actual=%0d expected=none", guess);
        end else begin
          checkOutput("guess", int'(guess), int'(exp_guess_q.pop_front()));
        end
      end
      if ((done || err) && prev_busy) begin
        if (result_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result actual=done%0d_err%0d expected=none", done, err);
        end else begin
          exp_t r;
          r = result_q.pop_front();
          checkOutput("done",  int'(done),  int'(r.d));
          checkOutput("err",   int'(err),   int'(r.e));
          checkOutput("found", int'(found), r.f);
          checkOutput("steps", int'(steps), r.s);
          checkOutput("guesses_left", exp_guess_q.size(), 0);
        end
      end
      prev_busy = busy;
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset state, directed cases, mid-search reset, random runs.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 0;
    hidden   = 0;
    #12;
    checkOutput("rst_guess", int'(guess), 0);
    checkOutput("rst_found", int'(found), 0);
    checkOutput("rst_steps", int'(steps), 0);
    checkOutput("rst_busy",  int'(busy),  0);
    checkOutput("rst_done",  int'(done),  0);
    checkOutput("rst_err",   int'(err),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);

    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 63, 1'b0);
    applyStimulus(0, 31, 1'b0);
    applyStimulus(0, 40, 1'b0);
    applyStimulus(1, 22, 1'b0);
    applyStimulus(0, 13, 1'b1);
    applyStimulus(2, 0, 1'b0);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(0, 5, 1'b0);

    // Asynchronous reset in the middle of a hidden=0 search, with an ignored
    // start pulse while busy beforehand.
    @(negedge clk);
    mode   = 0;
    hidden = 0;
    pushExpected(0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_guess", int'(guess), 0);
    checkOutput("arst_found", int'(found), 0);
    checkOutput("arst_steps", int'(steps), 0);
    checkOutput("arst_busy",  int'(busy),  0);
    checkOutput("arst_done",  int'(done),  0);
    checkOutput("arst_err",   int'(err),   0);
    exp_guess_q.delete();
    result_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_rst_busy", int'(busy), 0);

    for (int i = 0; i < 60; i++) begin
      int m;
      m = (i % 8 == 7) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(m, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("leftover_guesses", exp_guess_q.size(), 0);
    checkOutput("leftover_results", result_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_guesser.md
Name: sar_guesser

Overview:
- Successive-approximation (binary-search) guesser that drives the guess operand of the 6-bit magnitude comparator and consumes its 2-bit result.
- Finds a hidden value held on the comparator's other operand in at most WIDTH+1 guesses.
- Sits beside the comparator in the Lab3 guessing-game datapath: the comparator answers, this block asks.

Parameters:
- WIDTH, 6: operand width; must match the comparator operand width.
- STEP_W, 4: width of the step counter; must hold WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a search; honoured only in IDLE, DONE or ERR.
- cmp_in  input  2  comparator result for the current guess: 2'b10 = hidden > guess, 2'b01 = hidden < guess, 2'b00 = equal, 2'b11 = illegal.
- guess  output  WIDTH  current guess, driven to the comparator's second operand; registered.
- busy  output  1  high while searching (EVAL state).
- done  output  1  high in DONE; found is valid.
- err  output  1  high in ERR.
- found  output  WIDTH  located value; valid while done=1.
- steps  output  STEP_W  number of guesses presented in the current or last search.

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE; guess=0, found=0, steps=0; busy, done and err all 0; lo=0, hi=all-ones.
- Reset mid-search aborts immediately to the same values. Search restarts only on a new start.
- Internal registers:
  - lo and hi are WIDTH bits.
  - mid = (lo+hi)>>1, computed in WIDTH+1 bits so there is no overflow.
- States:
  - IDLE: start=1 loads lo=0, hi=2^WIDTH-1, guess=mid of that range (31 for WIDTH=6), steps=1, then goes to EVAL.
  - EVAL (busy=1): samples cmp_in every cycle, against the guess registered on the previous edge. One guess per cycle; the comparator is combinational.
    - 00: found=guess, go to DONE. guess holds.
    - 10: if guess==all-ones or guess+1>hi, go to ERR. Otherwise lo=guess+1, guess=mid(guess+1, hi), steps+1.
    - 01: if guess==0 or guess-1<lo, go to ERR. Otherwise hi=guess-1, guess=mid(lo, guess-1), steps+1.
    - 11: go to ERR immediately.
  - DONE (done=1): found, guess and steps hold. start restarts the search exactly as from IDLE, and done clears on that edge.
  - ERR (err=1): guess and steps hold; found=0. start restarts as from IDLE.
- start while busy is ignored; the search is not restarted.
- Latency: with k guesses, done or err asserts on the k-th rising edge after the edge that accepted start.
  - Worst case is k=WIDTH+1 (7 for WIDTH=6).
  - steps never exceeds WIDTH+1. If it would, go to ERR; this is unreachable with a consistent comparator.
- Outputs are registered only; there is no combinational path from cmp_in to any output.
- The ERR checks make the block robust to an inconsistent or illegal comparator. There is no wrap-around of lo or hi.

Test Plan:
- Hidden=0, behavioural comparator model, pulse start -> guesses 31, 15, 7, 3, 1, 0 on consecutive cycles; done=1, found=0, steps=6, busy low after the last guess.
- Hidden=63 -> guesses 31, 47, 55, 59, 61, 62, 63; done=1, found=63, steps=7 (the worst case).
- Hidden=31 -> first guess 31 returns 00; done on the 1st edge after start, found=31, steps=1. A start while in DONE with hidden=40 -> new search yields found=40.
- Forced cmp_in=2'b11 on the first EVAL cycle -> err=1, done=0, found=0, steps=1. A following start recovers and completes a normal search.
- Rogue driver holding cmp_in=2'b10 -> guesses 31, 47, 55, 59, 61, 62, 63, then 10 at 63 -> err=1, steps=7, no wrap to 0. A mirror case holding 01 ends at guess 0 -> err=1, steps=6.
- Hidden=0: assert rst_n=0 asynchronously (between edges) after the 3rd guess -> all outputs 0 immediately. A start pulse while busy (hidden=0) is checked to be ignored.
